seg7_scan_controller: RTL and testbench

//   Time-multiplexed drive controller for the board's 4-digit common-anode 7-segment display.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_hex_decoder.sv | 11 +
 rtl/seg7_scan_controller.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, glyph table and types for the 4-digit multiplexed 7-segment display driver.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low glyphs {g,f,e,d,c,b,a} for 0..9, A, b, C, d, E, F.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic        lz;
    } disp_buf_t;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_GLYPH[nibble_i];

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit common-anode display with
// ghost-suppression blanking and frame-synchronous double buffering.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] data_i,
    input  logic [3:0]  dp_i,
    input  logic        lz_suppress_i,
    input  logic        load_i,
    output logic        pending_o,
    output logic        frame_tick_o,
    output logic [1:0]  digit_idx_o,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    scan_state_e   state_q;
    logic [1:0]    digit_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic          frame_tick_q;

    disp_buf_t     active_q, active_d;
    disp_buf_t     shadow_q, shadow_d;
    logic          pending_q, pending_d;
    disp_buf_t     load_buf;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic          lead_zero;
    logic [6:0]    seg_show;
    logic          dp_show;

    assign slot_end  = (pcnt_q == PCNT_LAST);
    assign frame_end = slot_end && (digit_q == 2'd3);
    assign load_buf  = '{data: data_i, dp: dp_i, lz: lz_suppress_i};
    assign nibble    = active_q.data[{digit_q, 2'b00} +: 4];

    seg7_hex_decoder u_decoder (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    // A digit counts as a leading zero when it and every more significant nibble are zero.
    always_comb begin
        pcnt_d    = slot_end ? '0 : pcnt_q + PW'(1);
        lead_zero = ((active_q.data >> {digit_q, 2'b00}) == 16'h0000);
        seg_show  = (active_q.lz && (digit_q != 2'd0) && lead_zero) ? SEG_OFF : glyph;
        dp_show   = ~active_q.dp[digit_q];
    end

    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (frame_end && load_i) begin
            active_d  = load_buf;
            shadow_d  = load_buf;
            pending_d = 1'b0;
        end else if (frame_end && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (load_i) begin
            shadow_d  = load_buf;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt_q       <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_end;
        end
    end

    // Active data only changes on the slot end that enters BLANK, so SEG/DP are stable through SHOW.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BLANK;
            digit_q <= 2'd0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            case (state_q)
                BLANK: begin
                    if (pcnt_q == BLANK_LAST) begin
                        state_q <= SHOW;
                        an_q    <= ~(4'b0001 << digit_q);
                        seg_q   <= seg_show;
                        dp_q    <= dp_show;
                    end
                end
                SHOW: begin
                    if (slot_end) begin
                        state_q <= BLANK;
                        digit_q <= digit_q + 2'd1;
                        an_q    <= AN_OFF;
                        seg_q   <= SEG_OFF;
                        dp_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= BLANK;
                    an_q    <= AN_OFF;
                    seg_q   <= SEG_OFF;
                    dp_q    <= 1'b1;
                end
            endcase
        end
    end

    assign pending_o    = pending_q;
    assign frame_tick_o = frame_tick_q;
    assign digit_idx_o  = digit_q;
    assign an_o         = an_q;
    assign seg_o        = seg_q;
    assign dp_o         = dp_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller with DIV=8, BLANK_CYC=2 (8-cycle slots, 32-cycle frames).
module tb_seg7_scan_controller;

    typedef struct packed {
        logic [1:0] digit;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] dataIn;
    logic [3:0]  dpIn;
    logic        lzIn;
    logic        load;
    logic        pending;
    logic        frameTick;
    logic [1:0]  digitIdx;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    slot_t expQ[$];
    int    vectorCount = 0;
    int    missCount   = 0;
    int    cyc;
    int    blankRun    = 0;
    logic [3:0] prevAn = 4'hF;

    seg7_scan_controller #(.DIV(8), .BLANK_CYC(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .data_i        (dataIn),
        .dp_i          (dpIn),
        .lz_suppress_i (lzIn),
        .load_i        (load),
        .pending_o     (pending),
        .frame_tick_o  (frameTick),
        .digit_idx_o   (digitIdx),
        .an_o          (an),
        .seg_o         (seg),
        .dp_o          (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index since reset release; cycle k holds PCNT = k%8 and digit (k/8)%4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectorCount++;
        if (actual != expected) begin
            missCount++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic pushSlot(input logic [1:0] d, input logic [3:0] a, input logic [6:0] s, input logic p);
        slot_t e;
        e.digit = d;
        e.an    = a;
        e.seg   = s;
        e.dp    = p;
        expQ.push_back(e);
    endtask

    task automatic pushFrame(input logic [6:0] s0, input logic p0, input logic [6:0] s1, input logic p1,
                             input logic [6:0] s2, input logic p2, input logic [6:0] s3, input logic p3);
        pushSlot(2'd0, 4'b1110, s0, p0);
        pushSlot(2'd1, 4'b1101, s1, p1);
        pushSlot(2'd2, 4'b1011, s2, p2);
        pushSlot(2'd3, 4'b0111, s3, p3);
    endtask

    task automatic gotoCycle(input int c);
        int guard = 0;
        while (cyc != c && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != c) checkOutput("goto_timeout", cyc, c);
    endtask

    // Holds LOAD high for exactly the current cycle; returns 1 time unit into the next cycle.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p, input logic lz);
        dataIn = d;
        dpIn   = p;
        lzIn   = lz;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load   = 1'b0;
    endtask

    // Monitor: per-cycle overlap/blanking/frame-tick checks, slot scoreboard pop on each SHOW entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevAn   = 4'hF;
            blankRun = 0;
        end else begin
            slot_t e;
            checkOutput("frame_tick", int'(frameTick), (cyc != 0 && cyc % 32 == 0) ? 1 : 0);
            checkOutput("an_overlap", ($countones(~an) <= 1) ? 1 : 0, 1);
            if (an == 4'hF) begin
                blankRun++;
            end else begin
                if (prevAn == 4'hF) begin
                    checkOutput("blank_run", blankRun, 2);
                    if (expQ.size() == 0) begin
                        checkOutput("slot_queue_empty", int'(an), 15);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("slot_digit", int'(digitIdx), int'(e.digit));
                        checkOutput("slot_an", int'(an), int'(e.an));
                        checkOutput("slot_seg", int'(seg), int'(e.seg));
                        checkOutput("slot_dp", int'(dp), int'(e.dp));
                    end
                end else begin
                    checkOutput("an_stable", int'(an), int'(prevAn));
                end
                blankRun = 0;
            end
            prevAn = an;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        dataIn = 16'h0000;
        dpIn   = 4'h0;
        lzIn   = 1'b0;
        load   = 1'b0;
        pushFrame(7'h40, 1'b1, 7'h40, 1'b1, 7'h40, 1'b1, 7'h40, 1'b1);
        #12;
        checkOutput("reset_an", int'(an), 15);
        checkOutput("reset_seg", int'(seg), 'h7F);
        checkOutput("reset_dp", int'(dp), 1);
        checkOutput("reset_pending", int'(pending), 0);
        checkOutput("reset_digit", int'(digitIdx), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        gotoCycle(1);
        checkOutput("c1_an_blank", int'(an), 15);
        gotoCycle(2);
        checkOutput("c2_an_show", int'(an), 'hE);
        checkOutput("c2_seg_zero", int'(seg), 'h40);

        gotoCycle(5);
        applyStimulus(16'h12AF, 4'b0101, 1'b0);
        pushFrame(7'h0E, 1'b0, 7'h08, 1'b1, 7'h24, 1'b0, 7'h79, 1'b1);
        checkOutput("pending_after_load", int'(pending), 1);
        gotoCycle(31);
        checkOutput("pending_before_boundary", int'(pending), 1);
        gotoCycle(32);
        checkOutput("pending_after_boundary", int'(pending), 0);

        gotoCycle(40);
        applyStimulus(16'h0007, 4'b0000, 1'b1);
        pushFrame(7'h78, 1'b1, 7'h7F, 1'b1, 7'h7F, 1'b1, 7'h7F, 1'b1);

        gotoCycle(70);
        applyStimulus(16'h0000, 4'b0010, 1'b1);
        pushFrame(7'h40, 1'b1, 7'h7F, 1'b0, 7'h7F, 1'b1, 7'h7F, 1'b1);

        gotoCycle(100);
        applyStimulus(16'h1111, 4'b0000, 1'b0);
        checkOutput("pending_first_of_two", int'(pending), 1);
        gotoCycle(110);
        applyStimulus(16'h2222, 4'b0000, 1'b0);
        pushFrame(7'h24, 1'b1, 7'h24, 1'b1, 7'h24, 1'b1, 7'h24, 1'b1);

        gotoCycle(159);
        checkOutput("pending_idle_at_boundary", int'(pending), 0);
        applyStimulus(16'h5678, 4'b1000, 1'b0);
        pushFrame(7'h00, 1'b1, 7'h78, 1'b1, 7'h02, 1'b1, 7'h12, 1'b0);
        checkOutput("pending_boundary_load", int'(pending), 0);

        gotoCycle(170);
        applyStimulus(16'h9BCD, 4'b0000, 1'b0);
        pushFrame(7'h21, 1'b1, 7'h46, 1'b1, 7'h03, 1'b1, 7'h10, 1'b1);

        gotoCycle(200);
        applyStimulus(16'h0E03, 4'b0000, 1'b1);
        pushFrame(7'h30, 1'b1, 7'h40, 1'b1, 7'h06, 1'b1, 7'h7F, 1'b1);

        gotoCycle(241);
        applyStimulus(16'h0001, 4'b0000, 1'b0);
        checkOutput("pending_before_reset", int'(pending), 1);
        gotoCycle(243);
        checkOutput("digit2_showing", int'(an), 'hB);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_an", int'(an), 15);
        checkOutput("midreset_seg", int'(seg), 'h7F);
        checkOutput("midreset_dp", int'(dp), 1);
        checkOutput("midreset_pending", int'(pending), 0);
        checkOutput("midreset_digit", int'(digitIdx), 0);
        checkOutput("midreset_tick", int'(frameTick), 0);
        expQ.delete();
        pushFrame(7'h40, 1'b1, 7'h40, 1'b1, 7'h40, 1'b1, 7'h40, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("restart_digit", int'(digitIdx), 0);
        checkOutput("restart_an_blank", int'(an), 15);
        gotoCycle(1);
        checkOutput("restart_c1_blank", int'(an), 15);
        gotoCycle(32);
        checkOutput("queue_drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
